// File: rtl/probe_source.sv
// Leaf producer on the probe upstream link: snapshots PROBEDATA on a trigger and
// sends one packet (header + WORDS data words) over the DATAUP/DATAVALID/DELAY/ACK handshake.
module probe_source #(
   parameter logic [15:0] PROBE_ID = 16'h0000,
   parameter int          WORDS    = 2
) (
   input  logic                UCLK,
   input  logic                URST,
   input  logic                ENABLE,
   input  logic                TRIGGER,
   input  logic [32*WORDS-1:0] PROBEDATA,
   output logic [31:0]         DATAUP,
   output logic                DATAVALID,
   output logic                DELAY,
   input  logic                ACK,
   output logic                BUSY,
   output logic [7:0]          DROPS
);

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   localparam logic [7:0] WORDS_B  = 8'(WORDS);
   localparam logic [7:0] LAST_IDX = 8'(WORDS - 1);

   state_t              state;
   logic [7:0]          index;
   logic [32*WORDS-1:0] snapshot;
   logic                capture_req;
   logic                xfer;
   logic                last_xfer;
   logic                drop;
   logic [7:0]          next_index;
   logic [31:0]         next_word;
   logic [31:0]         header;

   assign capture_req = TRIGGER & ENABLE;
   assign xfer        = DATAVALID & ACK;
   assign last_xfer   = (state == DATA) && xfer && (index == LAST_IDX);
   // The last-word edge may start the next packet, so a trigger there is not a drop.
   assign drop        = capture_req && (state != IDLE) && !last_xfer;
   assign next_index  = index + 8'd1;
   assign header      = {PROBE_ID, DROPS, WORDS_B};
   assign BUSY        = DELAY;

   always_comb begin
      // NOTE: default assignment first so the word mux can never infer a latch.
      next_word = '0;
      for (int k = 0; k < WORDS; k++)
         if (next_index == 8'(k)) next_word = snapshot[32*k +: 32];
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge UCLK or posedge URST) begin
      if (URST) begin
         state     <= IDLE;
         index     <= '0;
         snapshot  <= '0;
         DATAUP    <= '0;
         DATAVALID <= 1'b0;
         DELAY     <= 1'b0;
         DROPS     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (capture_req) begin
                  snapshot  <= PROBEDATA;
                  DATAUP    <= header;
                  DATAVALID <= 1'b1;
                  DELAY     <= 1'b1;
                  state     <= HDR;
               end
            end
            HDR: begin
               if (xfer) begin
                  DATAUP <= snapshot[31:0];
                  index  <= '0;
                  state  <= DATA;
               end
            end
            DATA: begin
               if (xfer) begin
                  if (index != LAST_IDX) begin
                     index  <= next_index;
                     DATAUP <= next_word;
                  end else if (capture_req) begin
                     snapshot <= PROBEDATA;
                     DATAUP   <= header;
                     state    <= HDR;
                  end else begin
                     DATAVALID <= 1'b0;
                     DELAY     <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // Header transfer reports the count, so it restarts there (at 1 if dropping now).
         if (state == HDR && xfer)
            DROPS <= {7'd0, drop};
         else if (drop && DROPS != 8'hFF)
            DROPS <= DROPS + 8'd1;
      end
   end

endmodule

// File: tb/tb_probe_source.sv
// Scoreboard bench for probe_source: stimulus pushes expected upstream words,
// a negedge monitor pops and compares every word the DUT hands over.
module tb_probe_source;

   localparam logic [15:0] PID = 16'h00A5;
   localparam int          NW  = 2;

   logic          UCLK;
   logic          URST;
   logic          ENABLE;
   logic          TRIGGER;
   logic [63:0]   PROBEDATA;
   logic [31:0]   DATAUP;
   logic          DATAVALID;
   logic          DELAY;
   logic          ACK;
   logic          BUSY;
   logic [7:0]    DROPS;

   int            checks = 0;
   int            errors = 0;
   logic [31:0]   exp_q[$];

   probe_source #(.PROBE_ID(PID), .WORDS(NW)) dut (
      .UCLK      (UCLK),
      .URST      (URST),
      .ENABLE    (ENABLE),
      .TRIGGER   (TRIGGER),
      .PROBEDATA (PROBEDATA),
      .DATAUP    (DATAUP),
      .DATAVALID (DATAVALID),
      .DELAY     (DELAY),
      .ACK       (ACK),
      .BUSY      (BUSY),
      .DROPS     (DROPS)
   );

   initial UCLK = 1'b0;
   always #5 UCLK = ~UCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge UCLK);
      #1;
   endtask

   task automatic push_packet(input logic [63:0] pd, input logic [7:0] drops);
      exp_q.push_back({PID, drops, 8'h02});
      exp_q.push_back(pd[31:0]);
      exp_q.push_back(pd[63:32]);
   endtask

   // Monitor: a word shown with ACK high at the negedge transfers on the next rising edge.
   always @(negedge UCLK) begin
      if (!URST && DATAVALID && ACK) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none at %0t", DATAUP, $time);
         end else begin
            check("upstream_word", DATAUP, exp_q.pop_front());
         end
         check("delay_busy_with_valid", {30'd0, DELAY, BUSY}, 32'd3);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] p1;
      logic [63:0] p2;
      p1 = 64'h1111_2222_3333_4444;
      p2 = 64'hAAAA_BBBB_CCCC_DDDD;

      URST = 1'b1; ENABLE = 1'b0; TRIGGER = 1'b0; ACK = 1'b0; PROBEDATA = '0;
      #2;
      check("reset_dataup", DATAUP, 32'h0);
      check("reset_valid_delay_busy", {29'd0, DATAVALID, DELAY, BUSY}, 32'd0);
      check("reset_drops", {24'd0, DROPS}, 32'd0);
      tick(); tick();
      URST = 1'b0;

      // Basic packet, ACK tied high.
      ENABLE = 1'b1; ACK = 1'b1; PROBEDATA = p1;
      push_packet(p1, 8'h00);
      TRIGGER = 1'b1; tick(); TRIGGER = 1'b0;
      check("hdr_latency_valid", {31'd0, DATAVALID}, 32'd1);
      check("hdr_latency_word", DATAUP, 32'h00A5_0002);
      tick(); tick(); tick();
      check("basic_idle_valid_delay", {30'd0, DATAVALID, DELAY}, 32'd0);

      // Header held under ACK low; PROBEDATA change mid-packet must not leak.
      ACK = 1'b0;
      push_packet(p1, 8'h00);
      TRIGGER = 1'b1; tick(); TRIGGER = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("hdr_hold_word", DATAUP, 32'h00A5_0002);
         check("hdr_hold_valid", {31'd0, DATAVALID}, 32'd1);
         tick();
      end
      PROBEDATA = '0; ACK = 1'b1;
      check("hdr_hold_6th_cycle", DATAUP, 32'h00A5_0002);
      tick(); tick(); tick();
      check("hold_idle", {30'd0, DATAVALID, DELAY}, 32'd0);

      // Three drops during the body, reported in next header then cleared.
      PROBEDATA = p1;
      push_packet(p1, 8'h00);
      TRIGGER = 1'b1; tick(); TRIGGER = 1'b0;
      tick();
      ACK = 1'b0; TRIGGER = 1'b1;
      tick(); tick(); tick();
      TRIGGER = 1'b0;
      check("drops_three", {24'd0, DROPS}, 32'd3);
      ACK = 1'b1;
      tick(); tick();
      check("drops_kept_idle", {24'd0, DROPS}, 32'd3);
      push_packet(p1, 8'h03);
      TRIGGER = 1'b1; tick(); TRIGGER = 1'b0;
      check("drops_header", DATAUP, 32'h00A5_0302);
      tick();
      check("drops_cleared", {24'd0, DROPS}, 32'd0);
      tick(); tick();

      // Saturation: 300 triggers with ACK held low.
      ACK = 1'b0;
      push_packet(p1, 8'h00);
      TRIGGER = 1'b1; tick();
      for (int i = 0; i < 300; i++) tick();
      TRIGGER = 1'b0;
      check("drops_saturate", {24'd0, DROPS}, 32'hFF);
      check("sat_hdr_stable", DATAUP, 32'h00A5_0002);
      ACK = 1'b1;
      tick();
      check("sat_cleared", {24'd0, DROPS}, 32'd0);
      tick(); tick();

      // Back-to-back: trigger on the last-word transfer edge.
      push_packet(p1, 8'h00);
      TRIGGER = 1'b1; tick(); TRIGGER = 1'b0;
      tick(); tick();
      PROBEDATA = p2; TRIGGER = 1'b1;
      push_packet(p2, 8'h00);
      tick(); TRIGGER = 1'b0;
      check("b2b_valid", {31'd0, DATAVALID}, 32'd1);
      check("b2b_header", DATAUP, 32'h00A5_0002);
      check("b2b_drops", {24'd0, DROPS}, 32'd0);
      tick();
      check("b2b_word0", DATAUP, 32'hCCCC_DDDD);
      tick(); tick();
      check("b2b_idle", {30'd0, DATAVALID, DELAY}, 32'd0);

      // Asynchronous reset mid-DATA.
      PROBEDATA = p1;
      exp_q.push_back(32'h00A5_0002);
      TRIGGER = 1'b1; tick(); TRIGGER = 1'b0;
      tick();
      ACK = 1'b0; TRIGGER = 1'b1;
      tick(); TRIGGER = 1'b0;
      check("pre_reset_drops", {24'd0, DROPS}, 32'd1);
      #2 URST = 1'b1;
      #1;
      check("async_rst_valid_delay", {30'd0, DATAVALID, DELAY}, 32'd0);
      check("async_rst_dataup", DATAUP, 32'h0);
      check("async_rst_drops", {24'd0, DROPS}, 32'd0);
      tick();
      URST = 1'b0; ACK = 1'b1;
      push_packet(p1, 8'h00);
      TRIGGER = 1'b1; tick(); TRIGGER = 1'b0;
      check("post_rst_header", DATAUP, 32'h00A5_0002);
      tick(); tick(); tick();

      // ENABLE low: no packet, nothing counted.
      ENABLE = 1'b0; TRIGGER = 1'b1;
      tick(); tick(); tick();
      TRIGGER = 1'b0;
      check("disabled_no_packet", {30'd0, DATAVALID, DELAY}, 32'd0);
      check("disabled_no_drops", {24'd0, DROPS}, 32'd0);

      // ENABLE dropped mid-packet: packet completes, disabled triggers not counted.
      ENABLE = 1'b1; ACK = 1'b0;
      push_packet(p1, 8'h00);
      TRIGGER = 1'b1; tick();
      ENABLE = 1'b0;
      tick(); tick();
      TRIGGER = 1'b0;
      check("disabled_mid_drops", {24'd0, DROPS}, 32'd0);
      ACK = 1'b1;
      tick(); tick(); tick();
      check("disabled_mid_done", {30'd0, DATAVALID, DELAY}, 32'd0);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
